// File: rtl/mem_bank_router_pkg.sv
// Shared widths and types for the block-interleaved memory bank router.
package mem_bank_router_pkg;

   localparam int unsigned NUM_BANKS_DEF   = 4;
   localparam int unsigned BLOCK_WIDTH_DEF = 16;
   localparam int unsigned RSP_DEPTH_DEF   = 4;

   // Byte offset of the bank-select field: one cache block of 32-bit words.
   function automatic int unsigned off_f(input int unsigned block_width);
      return $clog2(block_width * 4);
   endfunction

   function automatic int unsigned bw_f(input int unsigned num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

   function automatic int unsigned cw_f(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef logic [bw_f(NUM_BANKS_DEF)-1:0] bank_idx_t;
   typedef logic [cw_f(RSP_DEPTH_DEF)-1:0] cnt_t;

endpackage

// File: rtl/mem_bank_router_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push while full is legal when popping.
module mbr_fifo #(
   parameter int unsigned width_p = 8,
   parameter int unsigned depth_p = 4
) (
   input  logic               clk_i,
   input  logic               nreset_i,
   input  logic               push_i,
   input  logic [width_p-1:0] wdata_i,
   input  logic               pop_i,
   output logic [width_p-1:0] rdata_o,
   output logic               full_o,
   output logic               empty_o
);
   localparam int unsigned   AW   = (depth_p > 1) ? $clog2(depth_p) : 1;
   localparam logic [AW-1:0] LAST = AW'(depth_p - 1);

   logic [width_p-1:0] mem [depth_p];
   logic [AW-1:0]      wr_idx, rd_idx;
   logic               wr_wrap, rd_wrap;
   logic               do_push, do_pop;

   always_comb begin
      empty_o = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
      full_o  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      rdata_o = mem[rd_idx];
   end

   // Indices wrap at depth_p; the wrap bit toggles to separate full from empty.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         wr_wrap <= 1'b0;
         rd_wrap <= 1'b0;
      end else begin
         if (do_push) begin
            wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + AW'(1);
            if (wr_idx == LAST) wr_wrap <= ~wr_wrap;
         end
         if (do_pop) begin
            rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + AW'(1);
            if (rd_idx == LAST) rd_wrap <= ~rd_wrap;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_idx] <= wdata_i;
   end

endmodule

// File: rtl/mem_bank_router.sv
// Routes bus requests to block-interleaved memory banks and returns reads in order.
// Optional per-bank stall counters: define MEM_BANK_ROUTER_PERF_EN.
module mem_bank_router
   import mem_bank_router_pkg::*;
#(
   parameter int unsigned num_banks_p      = 4,
   parameter int unsigned block_width_p    = 16,
   parameter int unsigned dma_data_width_p = 1,
   parameter int unsigned rsp_depth_p      = 4,
   parameter int unsigned ord_depth_p      = 8
) (
   input  logic                                             clk_i,
   input  logic                                             nreset_i,
   input  logic                                             req_valid_i,
   output logic                                             req_ready_o,
   input  logic                                             req_we_i,
   input  logic [31:0]                                      req_addr_i,
   input  logic [dma_data_width_p*32-1:0]                   req_wdata_i,
   output logic                                             rsp_valid_o,
   output logic [dma_data_width_p*32-1:0]                   rsp_data_o,
   output logic [num_banks_p-1:0]                           bk_valid_o,
   input  logic [num_banks_p-1:0]                           bk_ready_i,
   output logic                                             bk_we_o,
   output logic [31:0]                                      bk_addr_o,
   output logic [dma_data_width_p*32-1:0]                   bk_wdata_o,
   input  logic [num_banks_p-1:0]                           bk_valid_i,
   input  logic [num_banks_p-1:0][dma_data_width_p*32-1:0]  bk_data_i,
   output logic                                             err_o,
   output logic [num_banks_p-1:0][31:0]                     perf_stall_o
);
   localparam int unsigned D   = dma_data_width_p * 32;
   localparam int unsigned OFF = off_f(block_width_p);
   localparam int unsigned BW  = bw_f(num_banks_p);
   localparam int unsigned CW  = cw_f(rsp_depth_p);

   logic [BW-1:0]          bank_sel, head;
   logic [CW-1:0]          cnt [num_banks_p];
   logic                   ok, rd_acc, out_pop, ord_full, ord_empty;
   logic [D-1:0]           out_data;
   logic [D-1:0]           rb_rdata [num_banks_p];
   logic [num_banks_p-1:0] rb_full, rb_empty, rb_push, rb_pop;
   logic [num_banks_p-1:0] live_rsp, bank_pop, bypass, err_set;
   logic                   rsp_valid_q, err_q;
   logic [D-1:0]           rsp_data_q;

   if (num_banks_p == 1) begin : g_one_bank
      assign bank_sel = '0;
   end else begin : g_many_banks
      assign bank_sel = req_addr_i[OFF +: BW];
   end

   // Request path; all request-side outputs are held at zero while in reset.
   always_comb begin
      ok = nreset_i;
      if (!req_we_i) ok = nreset_i && !ord_full && (cnt[bank_sel] < CW'(rsp_depth_p));
      req_ready_o          = ok && bk_ready_i[bank_sel];
      bk_valid_o           = '0;
      bk_valid_o[bank_sel] = req_valid_i && ok;
      rd_acc               = req_valid_i && !req_we_i && req_ready_o;
      bk_we_o              = nreset_i && req_we_i;
      bk_addr_o            = nreset_i ? req_addr_i : '0;
      bk_wdata_o           = nreset_i ? req_wdata_i : '0;
   end

   // Output stage: a response arriving for the head bank while its buffer is empty bypasses it.
   always_comb begin
      out_pop  = 1'b0;
      out_data = '0;
      bank_pop = '0;
      for (int k = 0; k < num_banks_p; k++) live_rsp[k] = bk_valid_i[k] && (cnt[k] != '0);
      if (!ord_empty && (!rb_empty[head] || live_rsp[head])) begin
         out_pop        = 1'b1;
         bank_pop[head] = 1'b1;
         out_data       = rb_empty[head] ? bk_data_i[head] : rb_rdata[head];
      end
      for (int k = 0; k < num_banks_p; k++) begin
         bypass[k]  = bank_pop[k] && rb_empty[k];
         rb_pop[k]  = bank_pop[k] && !rb_empty[k];
         rb_push[k] = live_rsp[k] && !bypass[k] && (!rb_full[k] || rb_pop[k]);
         err_set[k] = bk_valid_i[k] && !bypass[k] && !rb_push[k];
      end
   end

   mbr_fifo #(.width_p(BW), .depth_p(ord_depth_p)) u_ord (
      .clk_i   (clk_i),
      .nreset_i(nreset_i),
      .push_i  (rd_acc),
      .wdata_i (bank_sel),
      .pop_i   (out_pop),
      .rdata_o (head),
      .full_o  (ord_full),
      .empty_o (ord_empty)
   );

   for (genvar k = 0; k < num_banks_p; k++) begin : g_bank
      mbr_fifo #(.width_p(D), .depth_p(rsp_depth_p)) u_rsp (
         .clk_i   (clk_i),
         .nreset_i(nreset_i),
         .push_i  (rb_push[k]),
         .wdata_i (bk_data_i[k]),
         .pop_i   (rb_pop[k]),
         .rdata_o (rb_rdata[k]),
         .full_o  (rb_full[k]),
         .empty_o (rb_empty[k])
      );
   end

   // Outstanding-read counters drop when the response leaves the router.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         for (int k = 0; k < num_banks_p; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < num_banks_p; k++) begin
            if ((rd_acc && bank_sel == BW'(k)) && !bank_pop[k]) cnt[k] <= cnt[k] + CW'(1);
            else if (!(rd_acc && bank_sel == BW'(k)) && bank_pop[k]) cnt[k] <= cnt[k] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= out_pop;
         if (out_pop) rsp_data_q <= out_data;
         if (|err_set) err_q <= 1'b1;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign err_o       = err_q;

`ifdef MEM_BANK_ROUTER_PERF_EN
   logic [31:0] stall_q [num_banks_p];

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         for (int k = 0; k < num_banks_p; k++) stall_q[k] <= '0;
      end else begin
         for (int k = 0; k < num_banks_p; k++) begin
            if (req_valid_i && !req_ready_o && bank_sel == BW'(k) && stall_q[k] != '1)
               stall_q[k] <= stall_q[k] + 32'd1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < num_banks_p; k++) perf_stall_o[k] = stall_q[k];
   end
`else
   assign perf_stall_o = '0;
`endif

endmodule

// File: doc/mem_bank_router.md
Name: mem_bank_router

Overview:
- Sits between the bus memory-side master interface and num_banks_p independent memory channels.
- Generalises the single-channel memory attachment to N block-interleaved banks, each with its own handshake.
- Tracks outstanding reads per bank in bounded buffers so banks may respond with different latencies.
- Returns read data to the bus strictly in request order.

Parameters:
- num_banks_p, 4, number of memory channels; power of two, 1..16.
- block_width_p, 16, words per cache block; sets the interleave granule.
- dma_data_width_p, 1, transfer width in 32-bit words.
- rsp_depth_p, 4, per-bank response buffer depth; also the per-bank outstanding-read limit.
- ord_depth_p, 8, depth of the global read-order queue; power of two.

Ports:
- clk_i  in  1  clock.
- nreset_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  bus request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  D  write data, where D = dma_data_width_p*32.
- rsp_valid_o  out  1  read data valid; single-cycle pulse, no backpressure.
- rsp_data_o  out  D  read data.
- bk_valid_o  out  num_banks_p  per-bank request valid.
- bk_ready_i  in  num_banks_p  per-bank request ready.
- bk_we_o  out  1  shared write enable; meaningful only where bk_valid_o is set.
- bk_addr_o  out  32  shared address, passed unmodified.
- bk_wdata_o  out  D  shared write data.
- bk_valid_i  in  num_banks_p  per-bank read response valid; no backpressure.
- bk_data_i  in  num_banks_p x D  per-bank read data.
- err_o  out  1  sticky error flag.
- perf_stall_o  out  num_banks_p x 32  per-bank stall counters.

Behaviour:
- Reset (asynchronous, active-low) sets all outputs to 0 and empties all queues and counters. Responses in flight are discarded; a bk_valid_i arriving after reset deassertion with an empty buffer is dropped and sets err_o.
- Bank select: b = req_addr_i[OFF +: BW], where OFF = $clog2(block_width_p*4) and BW = $clog2(num_banks_p). When num_banks_p = 1, b = 0. A whole block therefore maps to one bank.
- Request path is combinational, zero latency. bk_valid_o[b] = req_valid_i && ok. All other bk_valid_o bits are 0.
- Write: ok = 1. req_ready_o = bk_ready_i[b]. Writes produce no response.
- Read: ok = !ord_full && cnt[b] < rsp_depth_p. req_ready_o = bk_ready_i[b] && ok.
- On read accept: push b into the order queue and increment cnt[b].
- On bk_valid_i[k]: push bk_data_i[k] into bank k's response buffer.
- Output stage: when the order queue is non-empty and the buffer of head bank h is non-empty, pop both. Register the data and drive rsp_valid_o = 1 on the next cycle, then decrement cnt[h].
- Latency: a response that is already at the head of order appears one cycle after bk_valid_i. A response from a later bank waits until all earlier reads have been returned.
- At most one pop per cycle.
- Simultaneous increment and decrement of cnt[b] in one cycle leaves it unchanged.
- A push and a pop of the same buffer in one cycle are both legal, including when the buffer is full.
- Overflow: bk_valid_i[k] while bank k's buffer is full (a bank protocol violation) drops the data and sets err_o. err_o is cleared only by reset.
- Order-queue pointers wrap modulo ord_depth_p. Full and empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: MEM_BANK_ROUTER_PERF_EN.
- Defined: perf_stall_o[k] increments each cycle req_valid_i is high, b == k, and req_ready_o is low. Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: perf_stall_o is tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared package, mem_bank_router_pkg:
  - bank_idx_t, width max(1, BW).
  - cnt_t, width $clog2(rsp_depth_p+1).
  - OFF localparam function.
- One natural sub-module, mbr_fifo: parametrised width/depth synchronous FIFO with full/empty and simultaneous push/pop. It is instantiated once per bank for the response buffers and once for the order queue.

Test Plan:
- num_banks_p=4, block_width_p=16: reads to 0x000, 0x040, 0x080, 0x0C0 -> bk_valid_o = 0001, 0010, 0100, 1000. Banks respond in reverse order 3,2,1,0 -> rsp_data_o emerges in order 0,1,2,3, each one cycle apart after bank 0 responds.
- rsp_depth_p=4: five back-to-back reads to 0x000 with no responses -> 5th cycle has req_ready_o=0. One bank-0 response -> ready returns on the cycle after that response is popped.
- Write to 0x040 with bk_ready_i[1]=0 for 3 cycles -> req_ready_o low 3 cycles, no rsp_valid_o ever. With PERF_EN, perf_stall_o[1]=3.
- bk_valid_i[2] pulse with no outstanding read -> err_o=1 and stays 1 until nreset_i low. rsp_valid_o stays 0.
- nreset_i asserted with 3 reads outstanding -> all outputs 0 immediately; after release, a new read returns only its own data.
- ord_depth_p=8 full with reads spread over 4 banks -> 9th read stalls. Simultaneous pop and accept in one cycle keeps occupancy at 8, with no loss or reordering.
